axi_reg_arbiter: RTL and testbench
==================================

# axi_reg_arbiter

Two-master arbiter that shares the single AXI register slave port (`s_axi_reg`) between two upstream AXI masters, one whole transaction at a time. It grants round-robin, routes the granted master's AW/W/B or AR/R channels to the slave, and returns the response to that master. A response watchdog frees the bus with an error response if the slave never answers.

## Interface

Parameters:
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width; `wstrb` is `DATA_W/8` bits.
- `ID_W`, default 4, transaction ID width.
- `TIMEOUT_CYCLES`, default 256, response-phase watchdog limit; 0 disables the watchdog.

Ports (N = 0, 1 for the two masters):
- `clk`  in  1  single clock; everything is synchronous to the rising edge.
- `areset`  in  1  asynchronous, active-low reset.
- `mN_awid_i`/`mN_awaddr_i`/`mN_awvalid_i`  in  ID_W/ADDR_W/1  master write address; `mN_awready_o`  out  1.
- `mN_wdata_i`/`mN_wstrb_i`/`mN_wvalid_i`  in  DATA_W/DATA_W/8/1  master write data; `mN_wready_o`  out  1.
- `mN_bid_o`/`mN_bresp_o`/`mN_bvalid_o`  out  ID_W/2/1  master write response; `mN_bready_i`  in  1.
- `mN_arid_i`/`mN_araddr_i`/`mN_arvalid_i`  in  ID_W/ADDR_W/1  master read address; `mN_arready_o`  out  1.
- `mN_rid_o`/`mN_rdata_o`/`mN_rresp_o`/`mN_rvalid_o`  out  ID_W/DATA_W/2/1  master read data; `mN_rready_i`  in  1.
- `s_awid_o`/`s_awaddr_o`/`s_awvalid_o`  out  ID_W/ADDR_W/1; `s_awready_i`  in  1.
- `s_wdata_o`/`s_wstrb_o`/`s_wvalid_o`  out  DATA_W/DATA_W/8/1; `s_wready_i`  in  1.
- `s_bresp_i`/`s_bvalid_i`  in  2/1; `s_bready_o`  out  1.
- `s_arid_o`/`s_araddr_o`/`s_arvalid_o`  out  ID_W/ADDR_W/1; `s_arready_i`  in  1.
- `s_rdata_i`/`s_rresp_i`/`s_rvalid_i`  in  DATA_W/2/1; `s_rready_o`  out  1.

## Operation

- Requests: `req[N] = mN_awvalid_i | mN_arvalid_i`.
- States: IDLE, WR, RD, WR_ERR, RD_ERR. The grant register `g` (1 bit) and the round-robin pointer `ptr` (1 bit) are also registered.
- IDLE:
  - Every ready/valid output is 0.
  - If `req[ptr]`, grant `ptr`; otherwise, if `req[~ptr]`, grant `~ptr`.
  - Within the granted master, write wins when AW and AR are both valid.
  - Latch `g`, and latch awid or arid into `id_q`.
  - Go to WR or RD.
- WR:
  - AW and W pass through combinationally between master `g` and the slave.
  - Flags `aw_done`/`w_done` are set on their respective handshakes. Once a flag is set, the matching slave valid and master ready are held at 0. AW and W may complete in either order or in the same cycle.
  - B passes through: `mg_bvalid_o = s_bvalid_i`, `s_bready_o = mg_bready_i`, `mg_bid_o = id_q`.
  - On B handshake: go to IDLE, set `ptr <= ~g`, clear the flags.
- RD:
  - AR passes through until `ar_done`.
  - R passes through with `mg_rid_o = id_q`.
  - On R handshake: go to IDLE, set `ptr <= ~g`.
- The non-granted master always sees every ready and valid output at 0.
- Watchdog:
  - Counter `to_cnt` clears on entry to WR/RD. It increments only in the response phase (WR with `aw_done & w_done`, or RD with `ar_done`) while no response is valid.
  - When `to_cnt == TIMEOUT_CYCLES-1` and the response is still not valid, go to WR_ERR or RD_ERR.
- ERR states:
  - Slave `bready`/`rready` are 0.
  - Master `g` sees `bvalid`/`rvalid` = 1 with resp 2'b10 (SLVERR), `id_q`, and rdata 0.
  - On master ready: go to IDLE and set `ptr <= ~g`.
  - A late slave response is left unaccepted.
- Response codes from the slave are passed through unmodified.

## Timing

- Reset (asynchronous, `areset` = 0): state IDLE, `g` = 0, `ptr` = 0, flags and `to_cnt` = 0. All valid/ready outputs are 0 immediately, without waiting for a clock. All data/id/resp outputs are 0.
- Arbitration latency: request seen in IDLE at edge k; routing is active from cycle k+1. The first slave valid is asserted in cycle k+1.
- After the response handshake there is exactly 1 IDLE cycle before the next grant.
- Simultaneous requests in IDLE: `ptr` decides. Back-to-back requests from both masters therefore alternate: 0, 1, 0, ...
- A master that withdraws a request before the grant edge is not granted; grant is sampled at the edge.
- A request arriving while another transaction is in flight waits; there is no preemption.
- Timeout: with a stalled B, WR_ERR is entered `TIMEOUT_CYCLES` cycles after the later of the AW/W handshakes.
- Reset mid-transaction abandons the transaction; no response is generated.

## Test plan

- M0 writes addr 0xA3DD0000, data 0xC2CCEE2E, awid 3 -> slave sees the same values one cycle after the request; `m0_bvalid_o` = 1 with bid 3, bresp 00; `m1` outputs stay 0.
- M0 and M1 both assert awvalid in the same IDLE cycle after reset -> M0 is served first, then M1. Issuing two more requests from each gives the order M0, M1, M0, M1.
- M1 asserts AW and AR together -> write completes first; the read is granted on a later arbitration.
- W presented 2 cycles before AW, then AW and W in the same cycle -> each is accepted exactly once, and `s_wvalid_o` drops after its handshake.
- `TIMEOUT_CYCLES` = 8, slave never asserts bvalid -> 8 cycles after AW/W acceptance, `m0_bresp_o` = 10 with `bvalid` held until bready; the next request is then served normally.
- `areset` pulled low while in RD -> `s_arvalid_o`/`rvalid` outputs go to 0 asynchronously; after release the state is IDLE and `ptr` = 0.

Source files
------------

// File: rtl/axi_reg_arbiter.sv
// axi_reg_arbiter
//   Shares one AXI register slave port between two AXI masters, one whole
//   transaction at a time. Grants are round-robin. The granted master's AW/W/B
//   or AR/R channels are routed to the slave. A response watchdog answers the
//   master with SLVERR if the slave never responds.
//
// Ports
//   clk, areset        : clock, asynchronous active-low reset
//   mN_aw*/mN_w*/mN_b* : write address / data / response of master N (N = 0, 1)
//   mN_ar*/mN_r*       : read address / data of master N
//   s_aw*/s_w*/s_b*    : write channels towards the shared slave
//   s_ar*/s_r*         : read channels towards the shared slave
module axi_reg_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                areset,
    // master 0
    input  logic [ID_W-1:0]     m0_awid_i,
    input  logic [ADDR_W-1:0]   m0_awaddr_i,
    input  logic                m0_awvalid_i,
    output logic                m0_awready_o,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    input  logic                m0_wvalid_i,
    output logic                m0_wready_o,
    output logic [ID_W-1:0]     m0_bid_o,
    output logic [1:0]          m0_bresp_o,
    output logic                m0_bvalid_o,
    input  logic                m0_bready_i,
    input  logic [ID_W-1:0]     m0_arid_i,
    input  logic [ADDR_W-1:0]   m0_araddr_i,
    input  logic                m0_arvalid_i,
    output logic                m0_arready_o,
    output logic [ID_W-1:0]     m0_rid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic [1:0]          m0_rresp_o,
    output logic                m0_rvalid_o,
    input  logic                m0_rready_i,
    // master 1
    input  logic [ID_W-1:0]     m1_awid_i,
    input  logic [ADDR_W-1:0]   m1_awaddr_i,
    input  logic                m1_awvalid_i,
    output logic                m1_awready_o,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    input  logic                m1_wvalid_i,
    output logic                m1_wready_o,
    output logic [ID_W-1:0]     m1_bid_o,
    output logic [1:0]          m1_bresp_o,
    output logic                m1_bvalid_o,
    input  logic                m1_bready_i,
    input  logic [ID_W-1:0]     m1_arid_i,
    input  logic [ADDR_W-1:0]   m1_araddr_i,
    input  logic                m1_arvalid_i,
    output logic                m1_arready_o,
    output logic [ID_W-1:0]     m1_rid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic [1:0]          m1_rresp_o,
    output logic                m1_rvalid_o,
    input  logic                m1_rready_i,
    // slave
    output logic [ID_W-1:0]     s_awid_o,
    output logic [ADDR_W-1:0]   s_awaddr_o,
    output logic                s_awvalid_o,
    input  logic                s_awready_i,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    output logic                s_wvalid_o,
    input  logic                s_wready_i,
    input  logic [1:0]          s_bresp_i,
    input  logic                s_bvalid_i,
    output logic                s_bready_o,
    output logic [ID_W-1:0]     s_arid_o,
    output logic [ADDR_W-1:0]   s_araddr_o,
    output logic                s_arvalid_o,
    input  logic                s_arready_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    input  logic [1:0]          s_rresp_i,
    input  logic                s_rvalid_i,
    output logic                s_rready_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WR_ERR,
        S_RD_ERR
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_g, w_g_nxt;
    logic              r_ptr, w_ptr_nxt;
    logic [ID_W-1:0]   r_id_q, w_id_q_nxt;
    logic              r_aw_done, w_aw_done_nxt;
    logic              r_w_done, w_w_done_nxt;
    logic              r_ar_done, w_ar_done_nxt;
    logic [CNT_W-1:0]  r_to_cnt, w_to_cnt_nxt;

    // Inputs of the currently granted master.
    logic [ID_W-1:0]     w_g_awid, w_g_arid;
    logic [ADDR_W-1:0]   w_g_awaddr, w_g_araddr;
    logic [DATA_W-1:0]   w_g_wdata;
    logic [DATA_W/8-1:0] w_g_wstrb;
    logic                w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;

    assign w_g_awid    = r_g ? m1_awid_i    : m0_awid_i;
    assign w_g_awaddr  = r_g ? m1_awaddr_i  : m0_awaddr_i;
    assign w_g_awvalid = r_g ? m1_awvalid_i : m0_awvalid_i;
    assign w_g_wdata   = r_g ? m1_wdata_i   : m0_wdata_i;
    assign w_g_wstrb   = r_g ? m1_wstrb_i   : m0_wstrb_i;
    assign w_g_wvalid  = r_g ? m1_wvalid_i  : m0_wvalid_i;
    assign w_g_bready  = r_g ? m1_bready_i  : m0_bready_i;
    assign w_g_arid    = r_g ? m1_arid_i    : m0_arid_i;
    assign w_g_araddr  = r_g ? m1_araddr_i  : m0_araddr_i;
    assign w_g_arvalid = r_g ? m1_arvalid_i : m0_arvalid_i;
    assign w_g_rready  = r_g ? m1_rready_i  : m0_rready_i;

    // Round-robin pick: the pointer's master first, the other one otherwise.
    logic w_req0, w_req1, w_req_ptr, w_req_any, w_pick, w_pick_aw;
    logic [ID_W-1:0] w_pick_awid, w_pick_arid;

    assign w_req0      = m0_awvalid_i | m0_arvalid_i;
    assign w_req1      = m1_awvalid_i | m1_arvalid_i;
    assign w_req_ptr   = r_ptr ? w_req1 : w_req0;
    assign w_req_any   = w_req0 | w_req1;
    assign w_pick      = w_req_ptr ? r_ptr : ~r_ptr;
    assign w_pick_aw   = w_pick ? m1_awvalid_i : m0_awvalid_i;
    assign w_pick_awid = w_pick ? m1_awid_i : m0_awid_i;
    assign w_pick_arid = w_pick ? m1_arid_i : m0_arid_i;

    // Master-side view of the granted master, routed to m0 or m1 below.
    logic              w_awready_g, w_wready_g, w_bvalid_g, w_arready_g, w_rvalid_g;
    logic [1:0]        w_bresp_g, w_rresp_g;
    logic [ID_W-1:0]   w_bid_g, w_rid_g;
    logic [DATA_W-1:0] w_rdata_g;

    // NOTE: the state register resets asynchronously, so every output decoded
    // from it drops to 0 the moment areset falls, without a clock.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state   <= S_IDLE;
            r_g       <= 1'b0;
            r_ptr     <= 1'b0;
            r_id_q    <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_ar_done <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values.
            r_state   <= w_state_nxt;
            r_g       <= w_g_nxt;
            r_ptr     <= w_ptr_nxt;
            r_id_q    <= w_id_q_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_ar_done <= w_ar_done_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        w_state_nxt   = r_state;
        w_g_nxt       = r_g;
        w_ptr_nxt     = r_ptr;
        w_id_q_nxt    = r_id_q;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_ar_done_nxt = r_ar_done;
        w_to_cnt_nxt  = r_to_cnt;

        s_awid_o    = '0;
        s_awaddr_o  = '0;
        s_awvalid_o = 1'b0;
        s_wdata_o   = '0;
        s_wstrb_o   = '0;
        s_wvalid_o  = 1'b0;
        s_bready_o  = 1'b0;
        s_arid_o    = '0;
        s_araddr_o  = '0;
        s_arvalid_o = 1'b0;
        s_rready_o  = 1'b0;

        w_awready_g = 1'b0;
        w_wready_g  = 1'b0;
        w_bvalid_g  = 1'b0;
        w_bresp_g   = '0;
        w_bid_g     = '0;
        w_arready_g = 1'b0;
        w_rvalid_g  = 1'b0;
        w_rresp_g   = '0;
        w_rid_g     = '0;
        w_rdata_g   = '0;

        unique case (r_state)
            S_IDLE: begin
                w_aw_done_nxt = 1'b0;
                w_w_done_nxt  = 1'b0;
                w_ar_done_nxt = 1'b0;
                w_to_cnt_nxt  = '0;
                if (w_req_any) begin
                    w_g_nxt = w_pick;
                    if (w_pick_aw) begin
                        w_state_nxt = S_WR;
                        w_id_q_nxt  = w_pick_awid;
                    end else begin
                        w_state_nxt = S_RD;
                        w_id_q_nxt  = w_pick_arid;
                    end
                end
            end

            S_WR: begin
                // A completed channel is masked so it is never accepted twice.
                s_awid_o    = w_g_awid;
                s_awaddr_o  = w_g_awaddr;
                s_awvalid_o = w_g_awvalid & ~r_aw_done;
                w_awready_g = s_awready_i & ~r_aw_done;
                s_wdata_o   = w_g_wdata;
                s_wstrb_o   = w_g_wstrb;
                s_wvalid_o  = w_g_wvalid & ~r_w_done;
                w_wready_g  = s_wready_i & ~r_w_done;
                w_bvalid_g  = s_bvalid_i;
                w_bresp_g   = s_bresp_i;
                w_bid_g     = r_id_q;
                s_bready_o  = w_g_bready;

                if (s_awvalid_o && s_awready_i) w_aw_done_nxt = 1'b1;
                if (s_wvalid_o && s_wready_i)   w_w_done_nxt  = 1'b1;

                if (s_bvalid_i && w_g_bready) begin
                    w_state_nxt   = S_IDLE;
                    w_ptr_nxt     = ~r_g;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end else if (r_aw_done && r_w_done && !s_bvalid_i && TIMEOUT_CYCLES != 0) begin
                    if (r_to_cnt == TO_LAST) w_state_nxt  = S_WR_ERR;
                    else                     w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end

            S_RD: begin
                s_arid_o    = w_g_arid;
                s_araddr_o  = w_g_araddr;
                s_arvalid_o = w_g_arvalid & ~r_ar_done;
                w_arready_g = s_arready_i & ~r_ar_done;
                w_rvalid_g  = s_rvalid_i;
                w_rresp_g   = s_rresp_i;
                w_rdata_g   = s_rdata_i;
                w_rid_g     = r_id_q;
                s_rready_o  = w_g_rready;

                if (s_arvalid_o && s_arready_i) w_ar_done_nxt = 1'b1;

                if (s_rvalid_i && w_g_rready) begin
                    w_state_nxt   = S_IDLE;
                    w_ptr_nxt     = ~r_g;
                    w_ar_done_nxt = 1'b0;
                end else if (r_ar_done && !s_rvalid_i && TIMEOUT_CYCLES != 0) begin
                    if (r_to_cnt == TO_LAST) w_state_nxt  = S_RD_ERR;
                    else                     w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end

            // The slave's response channel stays blocked: a late answer is
            // simply never accepted.
            S_WR_ERR: begin
                w_bvalid_g = 1'b1;
                w_bresp_g  = RESP_SLVERR;
                w_bid_g    = r_id_q;
                if (w_g_bready) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = ~r_g;
                end
            end

            S_RD_ERR: begin
                w_rvalid_g = 1'b1;
                w_rresp_g  = RESP_SLVERR;
                w_rid_g    = r_id_q;
                if (w_g_rready) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = ~r_g;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The non-granted master always sees zeros.
    assign m0_awready_o = ~r_g & w_awready_g;
    assign m0_wready_o  = ~r_g & w_wready_g;
    assign m0_bvalid_o  = ~r_g & w_bvalid_g;
    assign m0_bresp_o   = r_g ? 2'b00 : w_bresp_g;
    assign m0_bid_o     = r_g ? '0 : w_bid_g;
    assign m0_arready_o = ~r_g & w_arready_g;
    assign m0_rvalid_o  = ~r_g & w_rvalid_g;
    assign m0_rresp_o   = r_g ? 2'b00 : w_rresp_g;
    assign m0_rid_o     = r_g ? '0 : w_rid_g;
    assign m0_rdata_o   = r_g ? '0 : w_rdata_g;

    assign m1_awready_o = r_g & w_awready_g;
    assign m1_wready_o  = r_g & w_wready_g;
    assign m1_bvalid_o  = r_g & w_bvalid_g;
    assign m1_bresp_o   = r_g ? w_bresp_g : 2'b00;
    assign m1_bid_o     = r_g ? w_bid_g : '0;
    assign m1_arready_o = r_g & w_arready_g;
    assign m1_rvalid_o  = r_g & w_rvalid_g;
    assign m1_rresp_o   = r_g ? w_rresp_g : 2'b00;
    assign m1_rid_o     = r_g ? w_rid_g : '0;
    assign m1_rdata_o   = r_g ? w_rdata_g : '0;

endmodule

// File: tb/tb_axi_reg_arbiter.sv
// Directed testbench for axi_reg_arbiter (TIMEOUT_CYCLES = 8).
module tb_axi_reg_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic areset = 1'b1;

    logic [IW-1:0] m0_awid = '0, m1_awid = '0, m0_arid = '0, m1_arid = '0;
    logic [AW-1:0] m0_awaddr = '0, m1_awaddr = '0, m0_araddr = '0, m1_araddr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic [SW-1:0] m0_wstrb = '0, m1_wstrb = '0;
    logic m0_awvalid = 0, m0_wvalid = 0, m0_bready = 0, m0_arvalid = 0, m0_rready = 0;
    logic m1_awvalid = 0, m1_wvalid = 0, m1_bready = 0, m1_arvalid = 0, m1_rready = 0;
    logic s_awready = 0, s_wready = 0, s_bvalid = 0, s_arready = 0, s_rvalid = 0;
    logic [1:0] s_bresp = '0, s_rresp = '0;
    logic [DW-1:0] s_rdata = '0;

    logic m0_awready_o, m0_wready_o, m0_bvalid_o, m0_arready_o, m0_rvalid_o;
    logic m1_awready_o, m1_wready_o, m1_bvalid_o, m1_arready_o, m1_rvalid_o;
    logic [IW-1:0] m0_bid_o, m1_bid_o, m0_rid_o, m1_rid_o;
    logic [1:0] m0_bresp_o, m1_bresp_o, m0_rresp_o, m1_rresp_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic [IW-1:0] s_awid_o, s_arid_o;
    logic [AW-1:0] s_awaddr_o, s_araddr_o;
    logic [DW-1:0] s_wdata_o;
    logic [SW-1:0] s_wstrb_o;
    logic s_awvalid_o, s_wvalid_o, s_bready_o, s_arvalid_o, s_rready_o;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    axi_reg_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .areset(areset),
        .m0_awid_i(m0_awid), .m0_awaddr_i(m0_awaddr), .m0_awvalid_i(m0_awvalid), .m0_awready_o(m0_awready_o),
        .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb), .m0_wvalid_i(m0_wvalid), .m0_wready_o(m0_wready_o),
        .m0_bid_o(m0_bid_o), .m0_bresp_o(m0_bresp_o), .m0_bvalid_o(m0_bvalid_o), .m0_bready_i(m0_bready),
        .m0_arid_i(m0_arid), .m0_araddr_i(m0_araddr), .m0_arvalid_i(m0_arvalid), .m0_arready_o(m0_arready_o),
        .m0_rid_o(m0_rid_o), .m0_rdata_o(m0_rdata_o), .m0_rresp_o(m0_rresp_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rready_i(m0_rready),
        .m1_awid_i(m1_awid), .m1_awaddr_i(m1_awaddr), .m1_awvalid_i(m1_awvalid), .m1_awready_o(m1_awready_o),
        .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb), .m1_wvalid_i(m1_wvalid), .m1_wready_o(m1_wready_o),
        .m1_bid_o(m1_bid_o), .m1_bresp_o(m1_bresp_o), .m1_bvalid_o(m1_bvalid_o), .m1_bready_i(m1_bready),
        .m1_arid_i(m1_arid), .m1_araddr_i(m1_araddr), .m1_arvalid_i(m1_arvalid), .m1_arready_o(m1_arready_o),
        .m1_rid_o(m1_rid_o), .m1_rdata_o(m1_rdata_o), .m1_rresp_o(m1_rresp_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rready_i(m1_rready),
        .s_awid_o(s_awid_o), .s_awaddr_o(s_awaddr_o), .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready),
        .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready_o),
        .s_arid_o(s_arid_o), .s_araddr_o(s_araddr_o), .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready),
        .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rvalid_i(s_rvalid), .s_rready_o(s_rready_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Called in the first WR cycle: accept AW+W together, return OKAY, then
    // land in the single IDLE cycle that follows.
    task automatic serve_write(input logic exp_g, input logic [IW-1:0] exp_id, input string tag);
        check({tag, "_s_awvalid"}, s_awvalid_o, 1);
        s_awready = 1; s_wready = 1; #1;
        check({tag, "_awready_g"},  exp_g ? m1_awready_o : m0_awready_o, 1);
        check({tag, "_awready_ng"}, exp_g ? m0_awready_o : m1_awready_o, 0);
        cyc();
        s_awready = 0; s_wready = 0;
        s_bvalid = 1; s_bresp = 2'b00; m0_bready = 1; m1_bready = 1; #1;
        check({tag, "_bvalid_g"},  exp_g ? m1_bvalid_o : m0_bvalid_o, 1);
        check({tag, "_bid_g"},     exp_g ? m1_bid_o : m0_bid_o, exp_id);
        check({tag, "_bvalid_ng"}, exp_g ? m0_bvalid_o : m1_bvalid_o, 0);
        cyc();
        s_bvalid = 0; m0_bready = 0; m1_bready = 0; #1;
        check({tag, "_idle_awvalid"}, s_awvalid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        // ---- reset: outputs zero without a clock edge
        #1 areset = 0; #1;
        check("rst_s_awvalid", s_awvalid_o, 0);
        check("rst_s_awaddr",  s_awaddr_o, 0);
        check("rst_m0_bvalid", m0_bvalid_o, 0);
        check("rst_m1_rvalid", m1_rvalid_o, 0);
        @(negedge clk); areset = 1;
        cyc();

        // ---- T1: basic write from M0
        m0_awid = 4'd3; m0_awaddr = 32'hA3DD0000; m0_awvalid = 1;
        m0_wdata = 32'hC2CCEE2E; m0_wstrb = 4'hF; m0_wvalid = 1; #1;
        check("t1_idle_awvalid", s_awvalid_o, 0);
        check("t1_idle_awready", m0_awready_o, 0);
        cyc();
        check("t1_s_awvalid", s_awvalid_o, 1);
        check("t1_s_awaddr",  s_awaddr_o, 32'hA3DD0000);
        check("t1_s_awid",    s_awid_o, 4'd3);
        check("t1_s_wvalid",  s_wvalid_o, 1);
        check("t1_s_wdata",   s_wdata_o, 32'hC2CCEE2E);
        check("t1_s_wstrb",   s_wstrb_o, 4'hF);
        s_awready = 1; s_wready = 1; #1;
        check("t1_m0_awready", m0_awready_o, 1);
        check("t1_m0_wready",  m0_wready_o, 1);
        check("t1_m1_awready", m1_awready_o, 0);
        cyc();
        check("t1_awvalid_masked", s_awvalid_o, 0);
        check("t1_awready_masked", m0_awready_o, 0);
        check("t1_wvalid_masked",  s_wvalid_o, 0);
        m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0;
        s_bvalid = 1; s_bresp = 2'b00; #1;
        check("t1_m0_bvalid", m0_bvalid_o, 1);
        check("t1_m0_bid",    m0_bid_o, 4'd3);
        check("t1_m0_bresp",  m0_bresp_o, 2'b00);
        check("t1_s_bready_lo", s_bready_o, 0);
        check("t1_m1_bvalid", m1_bvalid_o, 0);
        m0_bready = 1; #1;
        check("t1_s_bready_hi", s_bready_o, 1);
        cyc();
        s_bvalid = 0; m0_bready = 0; #1;
        check("t1_after_bvalid", m0_bvalid_o, 0);

        // ---- T2: simultaneous requests after reset alternate 0,1,0,1
        areset = 0; #1; areset = 1;
        m0_awid = 4'd1; m0_awvalid = 1; m0_wvalid = 1;
        m1_awid = 4'd2; m1_awaddr = 32'h0000_0100; m1_wdata = 32'h5555_AAAA; m1_wstrb = 4'h3;
        m1_awvalid = 1; m1_wvalid = 1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            serve_write(i[0], i[0] ? 4'd2 : 4'd1, "t2");
            if (i == 3) begin
                m0_awvalid = 0; m0_wvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
            end
            cyc();
        end

        // ---- T3: M1 AW and AR together: write first, read on a later grant
        m1_awid = 4'd6; m1_arid = 4'd5; m1_araddr = 32'h0000_0040;
        m1_awvalid = 1; m1_wvalid = 1; m1_arvalid = 1;
        cyc();
        check("t3_no_arvalid", s_arvalid_o, 0);
        serve_write(1'b1, 4'd6, "t3w");
        m1_awvalid = 0; m1_wvalid = 0;
        cyc();
        check("t3_s_arvalid", s_arvalid_o, 1);
        check("t3_s_araddr",  s_araddr_o, 32'h0000_0040);
        check("t3_s_arid",    s_arid_o, 4'd5);
        s_arready = 1; #1;
        check("t3_m1_arready", m1_arready_o, 1);
        check("t3_m0_arready", m0_arready_o, 0);
        cyc();
        s_arready = 0; m1_arvalid = 0;
        s_rvalid = 1; s_rdata = 32'h1234_5678; s_rresp = 2'b01; m1_rready = 1; #1;
        check("t3_m1_rvalid", m1_rvalid_o, 1);
        check("t3_m1_rdata",  m1_rdata_o, 32'h1234_5678);
        check("t3_m1_rresp",  m1_rresp_o, 2'b01);
        check("t3_m1_rid",    m1_rid_o, 4'd5);
        check("t3_m0_rvalid", m0_rvalid_o, 0);
        cyc();
        s_rvalid = 0; m1_rready = 0;

        // ---- T4: W accepted two cycles before AW
        m0_awid = 4'd7; m0_awaddr = 32'h0000_0010; m0_wdata = 32'hDEAD_BEEF;
        m0_awvalid = 1; m0_wvalid = 1;
        cyc();
        s_wready = 1; #1;
        check("t4_m0_wready",  m0_wready_o, 1);
        check("t4_m0_awready", m0_awready_o, 0);
        cyc();
        check("t4_wvalid_drop", s_wvalid_o, 0);
        check("t4_wready_drop", m0_wready_o, 0);
        s_wready = 0;
        cyc();
        check("t4_wvalid_still0", s_wvalid_o, 0);
        check("t4_awvalid_held",  s_awvalid_o, 1);
        s_awready = 1; #1;
        check("t4_m0_awready_hi", m0_awready_o, 1);
        cyc();
        check("t4_awvalid_drop", s_awvalid_o, 0);
        m0_awvalid = 0; m0_wvalid = 0; s_awready = 0;
        s_bvalid = 1; s_bresp = 2'b00; m0_bready = 1; #1;
        check("t4_m0_bid", m0_bid_o, 4'd7);
        cyc();
        s_bvalid = 0; m0_bready = 0;

        // ---- T5: B never arrives -> SLVERR after 8 cycles
        m0_awid = 4'd9; m0_awvalid = 1; m0_wvalid = 1;
        cyc();
        s_awready = 1; s_wready = 1;
        cyc();
        m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0;
        repeat (7) cyc();
        check("t5_not_yet", m0_bvalid_o, 0);
        cyc();
        check("t5_err_bvalid", m0_bvalid_o, 1);
        check("t5_err_bresp",  m0_bresp_o, 2'b10);
        check("t5_err_bid",    m0_bid_o, 4'd9);
        check("t5_s_bready",   s_bready_o, 0);
        cyc();
        check("t5_err_held", m0_bvalid_o, 1);
        s_bvalid = 1; s_bresp = 2'b00; m0_bready = 1; #1;
        check("t5_late_not_taken", s_bready_o, 0);
        check("t5_resp_still_err", m0_bresp_o, 2'b10);
        cyc();
        s_bvalid = 0; m0_bready = 0; #1;
        check("t5_err_cleared", m0_bvalid_o, 0);
        m0_arid = 4'd4; m0_araddr = 32'h0000_0020; m0_arvalid = 1;
        cyc();
        s_arready = 1; #1;
        check("t5_rd_arready", m0_arready_o, 1);
        cyc();
        s_arready = 0; m0_arvalid = 0;
        s_rvalid = 1; s_rdata = 32'hCAFE_F00D; s_rresp = 2'b00; m0_rready = 1; #1;
        check("t5_rd_rdata", m0_rdata_o, 32'hCAFE_F00D);
        check("t5_rd_rid",   m0_rid_o, 4'd4);
        cyc();
        s_rvalid = 0; m0_rready = 0;

        // ---- T6: reset mid-read
        m1_arid = 4'd2; m1_araddr = 32'h0000_0030; m1_arvalid = 1;
        cyc();
        check("t6_s_arvalid", s_arvalid_o, 1);
        s_rvalid = 1; s_rdata = 32'h0BAD_0BAD; #1;
        check("t6_m1_rvalid", m1_rvalid_o, 1);
        areset = 0; #1;
        check("t6_rst_arvalid", s_arvalid_o, 0);
        check("t6_rst_rvalid",  m1_rvalid_o, 0);
        check("t6_rst_araddr",  s_araddr_o, 0);
        s_rvalid = 0; m1_arvalid = 0; areset = 1;
        m0_arid = 4'd1; m0_arvalid = 1; m1_arvalid = 1;
        cyc();
        check("t6_ptr0_arid", s_arid_o, 4'd1);
        s_arready = 1; #1;
        check("t6_ptr0_m0_arready", m0_arready_o, 1);
        check("t6_ptr0_m1_arready", m1_arready_o, 0);
        cyc();
        s_arready = 0; m0_arvalid = 0; m1_arvalid = 0;
        s_rvalid = 1; m0_rready = 1;
        cyc();
        s_rvalid = 0; m0_rready = 0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
